// File: rtl/vga_framebuffer_reader.sv
// 640x480@60 scan-out: divide-by-2 pixel phase, linear read address, registered RGB/sync pins.
// Latency: a pixel reaches the pins one pixel (2 Clocks) after its counters; free-running, no backpressure.
module vga_framebuffer_reader #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  input  logic [DATA_WIDTH-1:0] iReadData,
  output logic                  oVGA_R,
  output logic                  oVGA_G,
  output logic                  oVGA_B,
  output logic                  oVGA_HSYNC,
  output logic                  oVGA_VSYNC,
  output logic                  oFrameStart,
  output logic                  oVisible
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(H_VISIBLE * V_VISIBLE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  logic                  phase;
  logic [9:0]            hcount;
  logic [9:0]            vcount;
  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0]            rgb;
  logic                  hsync;
  logic                  vsync;
  logic                  frame_start;
  logic                  visible_q;

  logic                  h_last;
  logic                  v_last;
  logic                  visible;
  logic                  in_hsync;
  logic                  in_vsync;
  logic [2:0]            pixel;
  logic [9:0]            hcount_next;
  logic [9:0]            vcount_next;
  logic [ADDR_WIDTH-1:0] addr_next;

  always_comb begin
    h_last      = (hcount == H_LAST);
    v_last      = (vcount == V_LAST);
    visible     = (hcount < H_VIS) && (vcount < V_VIS);
    in_hsync    = (hcount >= HS_FIRST) && (hcount <= HS_LAST);
    in_vsync    = (vcount >= VS_FIRST) && (vcount <= VS_LAST);
    // Blanking must never leak memory data, even undefined data, onto the pins.
    pixel       = visible ? iReadData[2:0] : 3'b000;
    hcount_next = h_last ? 10'd0 : hcount + 10'd1;
    vcount_next = vcount;
    if (h_last) begin
      vcount_next = v_last ? 10'd0 : vcount + 10'd1;
    end
    // Address tracks the next visible pixel; it saturates on the last one and holds through blanking.
    addr_next = addr;
    if (h_last && v_last) begin
      addr_next = '0;
    end else if (visible && (addr != ADDR_LAST)) begin
      addr_next = addr + ADDR_ONE;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      phase       <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      addr        <= '0;
      rgb         <= 3'b000;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      visible_q   <= 1'b0;
    end else begin
      phase       <= ~phase;
      frame_start <= phase & h_last & v_last;
      if (phase) begin
        hcount    <= hcount_next;
        vcount    <= vcount_next;
        addr      <= addr_next;
        rgb       <= pixel;
        hsync     <= ~in_hsync;
        vsync     <= ~in_vsync;
        visible_q <= visible;
      end
    end
  end

  assign oReadAddress = addr;
  assign oVGA_R       = rgb[2];
  assign oVGA_G       = rgb[1];
  assign oVGA_B       = rgb[0];
  assign oVGA_HSYNC   = hsync;
  assign oVGA_VSYNC   = vsync;
  assign oFrameStart  = frame_start;
  assign oVisible     = visible_q;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Directed bench for vga_framebuffer_reader on a scaled-down raster (24x12 total, 16x6 visible)
// so that whole frames, vertical blanking and mid-frame reset fit in a short run.
module tb_vga_framebuffer_reader;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int ALAST = HV * VV - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] rd_addr;
  logic [2:0]  rd_data = 3'b000;
  logic        r, g, b, hs, vs, fs, vis;
  logic        mem_junk = 1'b1;
  logic        junk_x = 1'b0;

  int checks = 0;
  int errors = 0;
  int hs_low, hs_first, vs_low, vs_first, fs_cnt, fs_edge;

  vga_framebuffer_reader #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .ADDR_WIDTH(19), .DATA_WIDTH(3)
  ) dut (
    .Clock(clk), .Reset(rst_n), .oReadAddress(rd_addr), .iReadData(rd_data),
    .oVGA_R(r), .oVGA_G(g), .oVGA_B(b), .oVGA_HSYNC(hs), .oVGA_VSYNC(vs),
    .oFrameStart(fs), .oVisible(vis)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data = address[2:0]; junk (111 or X) whenever the bench knows the pixel is blank.
  always @(posedge clk) begin
    if (mem_junk) rd_data <= junk_x ? 3'bxxx : 3'b111;
    else          rd_data <= rd_addr[2:0];
  end

  function automatic int addr_of(input int h, input int v);
    int a;
    a = v * HV + ((h < HV) ? h : HV);
    return (a > ALAST) ? ALAST : a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // e = Clocks since the last edge that sampled reset low.
  task automatic sample_stats(input int e);
    if (e <= 2 * HT && !hs) begin
      hs_low++;
      if (hs_first < 0) hs_first = e;
    end
    if (e <= 2 * FRAME) begin
      if (!vs) begin
        vs_low++;
        if (vs_first < 0) vs_first = e;
      end
      if (fs) begin
        fs_cnt++;
        fs_edge = e;
      end
    end
  endtask

  task automatic run_frames(input int nframes);
    hs_low = 0; hs_first = -1; vs_low = 0; vs_first = -1; fs_cnt = 0; fs_edge = -1;
    for (int p = 0; p < nframes * FRAME; p++) begin
      int pf, h, v;
      logic [31:0] av;
      logic on;
      pf = p % FRAME;
      h  = pf % HT;
      v  = pf / HT;
      on = (h < HV) && (v < VV);
      av = addr_of(h, v);
      check("read_address", {13'd0, rd_addr}, av);
      mem_junk = !on;
      junk_x   = (p % 2) == 1;
      tick();
      sample_stats(2 * p + 1);
      check("frame_start_mid", {31'd0, fs}, 32'd0);
      check("read_address_hold", {13'd0, rd_addr}, av);
      tick();
      sample_stats(2 * p + 2);
      check("rgb", {29'd0, r, g, b}, on ? {29'd0, av[2:0]} : 32'd0);
      check("hsync", {31'd0, hs}, (h >= HV + HF && h < HV + HF + HS) ? 32'd0 : 32'd1);
      check("vsync", {31'd0, vs}, (v >= VV + VF && v < VV + VF + VS) ? 32'd0 : 32'd1);
      check("visible", {31'd0, vis}, {31'd0, on});
      check("frame_start", {31'd0, fs}, (pf == FRAME - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_frame_stats(input string run);
    check({run, "_hsync_low_clocks"}, hs_low, 6);
    check({run, "_hsync_first_low"}, hs_first, 38);
    check({run, "_vsync_low_clocks"}, vs_low, 96);
    check({run, "_vsync_first_low"}, vs_first, 386);
    check({run, "_frame_start_count"}, fs_cnt, 1);
    check({run, "_frame_start_clock"}, fs_edge, 576);
  endtask

  task automatic check_reset_state(input string run);
    check({run, "_rgb"}, {29'd0, r, g, b}, 32'd0);
    check({run, "_hsync"}, {31'd0, hs}, 32'd1);
    check({run, "_vsync"}, {31'd0, vs}, 32'd1);
    check({run, "_frame_start"}, {31'd0, fs}, 32'd0);
    check({run, "_visible"}, {31'd0, vis}, 32'd0);
    check({run, "_read_address"}, {13'd0, rd_addr}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) tick();
    check_reset_state("reset");
    rst_n = 1'b1;

    run_frames(2);
    check_frame_stats("run1");

    // Advance to the start of pixel (8,3), then halfway into it.
    repeat (2 * (3 * HT + 8)) tick();
    check("addr_at_8_3", {13'd0, rd_addr}, 32'd56);
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_state("midframe_reset");
    rst_n = 1'b1;

    run_frames(1);
    check_frame_stats("run2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
